// File: rtl/ctrl_mapper.sv
// Merges PS/2 key states with per-player joystick words into registered controller outputs.
// Coin inputs become fixed-length pulses; pause is either a toggle latch or a registered level.
module ctrl_mapper #(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 3,
  parameter int COIN_PULSE   = 16,
  parameter int PAUSE_TOGGLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            ps2_key,
  input  logic [PLAYERS*16-1:0]  joystick,
  output logic [PLAYERS*16-1:0]  player
);

  localparam int KP = (PLAYERS < 2) ? PLAYERS : 2;
  localparam logic [15:0] BTN_MASK = 16'(((1 << BUTTONS) - 1) << 4);
  localparam logic [15:0] LVL_MASK = 16'h240F | BTN_MASK | ((PAUSE_TOGGLE != 0) ? 16'h0000 : 16'h1000);

  logic        tog_q;
  logic        key_evt;
  logic        key_hit;
  logic        key_p2;
  logic [3:0]  key_bit;
  logic [15:0] key_state [KP];
  logic        unused_ext;

  assign unused_ext = ps2_key[8];
  assign key_evt    = ps2_key[10] != tog_q;

  always_comb begin
    key_hit = 1'b1;
    key_p2  = 1'b0;
    key_bit = 4'd0;
    case (ps2_key[7:0])
      8'h74: key_bit = 4'd0;
      8'h6B: key_bit = 4'd1;
      8'h72: key_bit = 4'd2;
      8'h75: key_bit = 4'd3;
      8'h14: key_bit = 4'd4;
      8'h11: key_bit = 4'd5;
      8'h29: key_bit = 4'd6;
      8'h16: key_bit = 4'd10;
      8'h2E: key_bit = 4'd11;
      8'h4D: key_bit = 4'd12;
      8'h46: key_bit = 4'd13;
      8'h34: begin key_p2 = 1'b1; key_bit = 4'd0;  end
      8'h23: begin key_p2 = 1'b1; key_bit = 4'd1;  end
      8'h2B: begin key_p2 = 1'b1; key_bit = 4'd2;  end
      8'h2D: begin key_p2 = 1'b1; key_bit = 4'd3;  end
      8'h1C: begin key_p2 = 1'b1; key_bit = 4'd4;  end
      8'h1B: begin key_p2 = 1'b1; key_bit = 4'd5;  end
      8'h15: begin key_p2 = 1'b1; key_bit = 4'd6;  end
      8'h1E: begin key_p2 = 1'b1; key_bit = 4'd10; end
      8'h36: begin key_p2 = 1'b1; key_bit = 4'd11; end
      8'h45: begin key_p2 = 1'b1; key_bit = 4'd13; end
      default: key_hit = 1'b0;
    endcase
    if (key_p2 && (KP < 2)) key_hit = 1'b0;
  end

  // The toggle history tracks ps2_key even in reset so release never looks like an event.
  always_ff @(posedge clk) begin
    tog_q <= ps2_key[10];
    if (!rst_n) begin
      for (int k = 0; k < KP; k++) key_state[k] <= '0;
    end else if (key_evt && key_hit) begin
      for (int k = 0; k < KP; k++)
        if ((k == 1) == key_p2) key_state[k][key_bit] <= ps2_key[9];
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    logic [15:0] keys;
    logic [15:0] merged;
    logic [15:0] lvl_q;
    logic [15:0] cnt;
    logic        coin_prev;
    logic        pause_prev;
    logic        pause_lat;
    logic        pause_bit;
    logic        coin_bit;

    if (p < KP) begin : g_keys
      assign keys = key_state[p];
    end else begin : g_nokeys
      assign keys = '0;
    end

    assign merged = keys | joystick[16*p +: 16];

    // Edge history samples the joystick during reset so a held input is not an edge on release.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lvl_q      <= '0;
        cnt        <= '0;
        pause_lat  <= 1'b0;
        coin_prev  <= joystick[16*p+11];
        pause_prev <= joystick[16*p+12];
      end else begin
        lvl_q      <= merged & LVL_MASK;
        coin_prev  <= merged[11];
        pause_prev <= merged[12];
        if (cnt != 16'd0)
          cnt <= cnt - 16'd1;
        else if (merged[11] && !coin_prev)
          cnt <= 16'(COIN_PULSE);
        if (merged[12] && !pause_prev) pause_lat <= ~pause_lat;
      end
    end

    assign coin_bit  = cnt != 16'd0;
    assign pause_bit = (PAUSE_TOGGLE != 0) && pause_lat;
    assign player[16*p +: 16] = lvl_q | {3'b000, pause_bit, coin_bit, 11'h000};
  end

endmodule

// File: tb/tb_ctrl_mapper.sv
// Randomised and directed bench for ctrl_mapper, checked against a cycle-level behavioural model.
module tb_ctrl_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [10:0] ps2_key;
  logic [31:0] joy_a;
  logic [63:0] joy_b;
  logic [31:0] pl_a;
  logic [63:0] pl_b;

  int n_tests = 0;
  int n_fail  = 0;

  ctrl_mapper #(.PLAYERS(2), .BUTTONS(3), .COIN_PULSE(16), .PAUSE_TOGGLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joystick(joy_a), .player(pl_a));

  ctrl_mapper #(.PLAYERS(4), .BUTTONS(2), .COIN_PULSE(16), .PAUSE_TOGGLE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joystick(joy_b), .player(pl_b));

  int cfg_players[2] = '{2, 4};
  int cfg_buttons[2] = '{3, 2};
  int cfg_pt[2]      = '{1, 0};

  int key_code[21] = '{'h75, 'h72, 'h6B, 'h74, 'h14, 'h11, 'h29, 'h16, 'h2E, 'h4D, 'h46,
                       'h2D, 'h2B, 'h23, 'h34, 'h1C, 'h1B, 'h15, 'h1E, 'h36, 'h45};
  int key_pl[21]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int key_bitn[21] = '{3, 2, 1, 0, 4, 5, 6, 10, 11, 12, 13,
                       3, 2, 1, 0, 4, 5, 6, 10, 11, 13};

  logic [15:0] m_key[2][4];
  logic [15:0] m_lvl[2][4];
  logic [15:0] m_exp[2][4];
  int          m_cnt[2][4];
  logic        m_pc[2][4];
  logic        m_pp[2][4];
  logic        m_lat[2][4];
  logic        m_tog[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic rst, input logic [10:0] key, input logic [63:0] joy);
    logic [15:0] merged;
    logic [15:0] lvl_mask;
    lvl_mask = 16'h240F | (16'((1 << cfg_buttons[i]) - 1) << 4);
    if (cfg_pt[i] == 0) lvl_mask = lvl_mask | 16'h1000;
    for (int p = 0; p < cfg_players[i]; p++) begin
      if (!rst) begin
        m_key[i][p] = '0;
        m_lvl[i][p] = '0;
        m_cnt[i][p] = 0;
        m_lat[i][p] = 1'b0;
        m_pc[i][p]  = joy[16*p+11];
        m_pp[i][p]  = joy[16*p+12];
      end else begin
        merged = m_key[i][p] | joy[16*p +: 16];
        m_lvl[i][p] = merged & lvl_mask;
        if (m_cnt[i][p] > 0) m_cnt[i][p] = m_cnt[i][p] - 1;
        else if (merged[11] && !m_pc[i][p]) m_cnt[i][p] = 16;
        if (merged[12] && !m_pp[i][p]) m_lat[i][p] = !m_lat[i][p];
        m_pc[i][p] = merged[11];
        m_pp[i][p] = merged[12];
      end
      m_exp[i][p] = m_lvl[i][p] | ((m_cnt[i][p] != 0) ? 16'h0800 : 16'h0000)
                  | ((cfg_pt[i] != 0 && m_lat[i][p]) ? 16'h1000 : 16'h0000);
    end
    if (rst && key[10] != m_tog[i]) begin
      for (int e = 0; e < 21; e++)
        if (key[7:0] == key_code[e][7:0] && key_pl[e] < cfg_players[i])
          m_key[i][key_pl[e]][key_bitn[e]] = key[9];
    end
    m_tog[i] = key[10];
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, rst_n, ps2_key, {32'h0, joy_a});
    model_step(1, rst_n, ps2_key, joy_b);
    #1;
    check("word_a", {32'h0, pl_a}, {32'h0, m_exp[0][1], m_exp[0][0]});
    check("word_b", pl_b, {m_exp[1][3], m_exp[1][2], m_exp[1][1], m_exp[1][0]});
    @(negedge clk);
  endtask

  task automatic key_ev(input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  initial begin
    int hi;
    int b;
    int idx;
    int code;
    rst_n   = 1'b0;
    ps2_key = '0;
    joy_a   = '0;
    joy_b   = '0;
    @(negedge clk);
    repeat (3) cycle();
    check("reset_a", {32'h0, pl_a}, 64'h0);
    check("reset_b", pl_b, 64'h0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // key up press/release, two-cycle latency
    key_ev(1'b1, 8'h75);
    cycle();
    check("up_lat1", {63'h0, pl_a[3]}, 64'd0);
    cycle();
    check("up_on", {63'h0, pl_a[3]}, 64'd1);
    key_ev(1'b0, 8'h75);
    cycle();
    cycle();
    check("up_off", {63'h0, pl_a[3]}, 64'd0);

    // coin pulse length and re-arm
    joy_a[11] = 1'b1;
    hi = 0;
    for (int k = 0; k < 40; k++) begin cycle(); hi += int'(pl_a[11]); end
    check("coin_len1", 64'(hi), 64'd16);
    joy_a[11] = 1'b0;
    cycle();
    joy_a[11] = 1'b1;
    hi = 0;
    for (int k = 0; k < 40; k++) begin cycle(); hi += int'(pl_a[11]); end
    check("coin_len2", 64'(hi), 64'd16);
    joy_a[11] = 1'b0;
    repeat (2) cycle();

    // pause: toggle on A, level on B
    key_ev(1'b1, 8'h4D); cycle(); cycle();
    check("pause_a1", {63'h0, pl_a[12]}, 64'd1);
    check("pause_b1", {63'h0, pl_b[12]}, 64'd1);
    key_ev(1'b0, 8'h4D); cycle(); cycle();
    check("pause_a2", {63'h0, pl_a[12]}, 64'd1);
    check("pause_b2", {63'h0, pl_b[12]}, 64'd0);
    key_ev(1'b1, 8'h4D); cycle(); cycle();
    check("pause_a3", {63'h0, pl_a[12]}, 64'd0);
    check("pause_b3", {63'h0, pl_b[12]}, 64'd1);
    key_ev(1'b0, 8'h4D); cycle(); cycle();

    // P4 all-ones word with two buttons
    joy_b[63:48] = 16'h3FFF;
    cycle();
    check("p4_first", {48'h0, pl_b[63:48]}, 64'h3C3F);
    hi = 1;
    for (int k = 0; k < 20; k++) begin cycle(); hi += int'(pl_b[59]); end
    check("p4_coin_len", 64'(hi), 64'd16);
    check("p4_steady", {48'h0, pl_b[63:48]}, 64'h343F);
    joy_b = '0;
    cycle();

    // P2 key on the four-player instance
    key_ev(1'b1, 8'h2D); cycle(); cycle();
    check("p2_up_b", {63'h0, pl_b[19]}, 64'd1);
    key_ev(1'b0, 8'h2D); cycle(); cycle();

    // reset mid coin pulse, ps2 toggle during reset
    joy_a[11] = 1'b1;
    repeat (5) cycle();
    check("coin_pre_rst", {63'h0, pl_a[11]}, 64'd1);
    rst_n = 1'b0;
    key_ev(1'b1, 8'h75);
    cycle();
    check("coin_rst", {63'h0, pl_a[11]}, 64'd0);
    rst_n = 1'b1;
    repeat (4) cycle();
    check("rst_no_key", {63'h0, pl_a[3]}, 64'd0);
    check("rst_no_coin", {63'h0, pl_a[11]}, 64'd0);
    joy_a[11] = 1'b0;
    cycle();

    // key and joystick on the same button, key released first
    key_ev(1'b1, 8'h14);
    joy_a[4] = 1'b1;
    cycle(); cycle();
    check("btn_both", {63'h0, pl_a[4]}, 64'd1);
    key_ev(1'b0, 8'h14);
    repeat (4) cycle();
    check("btn_joy_hold", {63'h0, pl_a[4]}, 64'd1);
    joy_a[4] = 1'b0;
    cycle();
    check("btn_drop", {63'h0, pl_a[4]}, 64'd0);

    // opposing directions
    joy_a[3:0] = 4'hF;
    cycle();
    check("opposing", {60'h0, pl_a[3:0]}, 64'hF);
    joy_a = '0;
    cycle();

    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 31);
        joy_a[b] = ~joy_a[b];
      end
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 63);
        joy_b[b] = ~joy_b[b];
      end
      if ($urandom_range(0, 4) == 0) begin
        idx  = $urandom_range(0, 24);
        code = (idx < 21) ? key_code[idx] : int'($urandom_range(0, 255));
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), code[7:0]};
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
